// File: rtl/voting_pkg.sv
// Shared definitions for the ballot collector: default sizing and the FSM state type.
package voting_pkg;

  localparam int NUM_VOTERS_DEF = 16;
  localparam int ID_W_DEF       = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/voting_ballot_collector_if.sv
// Vote-in / ballot-out bundle of the ballot collector; the collector takes the slave modport.
// Optional tally/majority signals exist only when VOTING_BALLOT_TALLY_EN is defined.
interface voting_ballot_collector_if
  import voting_pkg::*;
#(
  parameter int NUM_VOTERS = NUM_VOTERS_DEF,
  parameter int ID_W       = ID_W_DEF
);

  logic                  vote_valid;
  logic                  vote_ready;
  logic [ID_W-1:0]       vote_id;
  logic                  vote_value;
  logic                  close;
  logic                  ballot_valid;
  logic                  ballot_ready;
  logic [NUM_VOTERS-1:0] ballot;
  logic [NUM_VOTERS-1:0] ballot_mask;
  logic                  dup_err;
`ifdef VOTING_BALLOT_TALLY_EN
  logic [ID_W:0]         tally;
  logic                  majority;
`endif

  modport master (
    output vote_valid, vote_id, vote_value, close, ballot_ready,
`ifdef VOTING_BALLOT_TALLY_EN
    input  tally, majority,
`endif
    input  vote_ready, ballot_valid, ballot, ballot_mask, dup_err
  );

  modport slave (
    input  vote_valid, vote_id, vote_value, close, ballot_ready,
`ifdef VOTING_BALLOT_TALLY_EN
    output tally, majority,
`endif
    output vote_ready, ballot_valid, ballot, ballot_mask, dup_err
  );

endinterface

// File: rtl/voting_ballot_collector.sv
// Collects one vote per voter slot, then presents the ballot to the voting circuit.
// Define VOTING_BALLOT_TALLY_EN to add an incrementally maintained tally and majority flag.
module voting_ballot_collector
  import voting_pkg::*;
#(
  parameter int NUM_VOTERS = NUM_VOTERS_DEF,
  parameter int ID_W       = ID_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  voting_ballot_collector_if.slave bus
);

  state_e                state_q, state_d;
  logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
  logic [NUM_VOTERS-1:0] mask_q, mask_d;
  logic                  dup_q, dup_d;
  logic [NUM_VOTERS-1:0] slot_s;
  logic                  accept_s;
  logic                  is_dup_s;

  // Next-state, ballot update and duplicate detection.
  always_comb begin
    state_d  = state_q;
    ballot_d = ballot_q;
    mask_d   = mask_q;
    dup_d    = 1'b0;
    accept_s = bus.vote_valid & (state_q == COLLECT);
    slot_s   = {{(NUM_VOTERS-1){1'b0}}, 1'b1} << bus.vote_id;
    is_dup_s = |(mask_q & slot_s);
    case (state_q)
      COLLECT: begin
        if (accept_s && is_dup_s) begin
          dup_d = 1'b1;
        end else if (accept_s) begin
          mask_d   = mask_q | slot_s;
          ballot_d = bus.vote_value ? (ballot_q | slot_s) : ballot_q;
        end else begin
          dup_d = 1'b0;
        end
        // A vote arriving with close is folded in before presenting.
        if (bus.close || (&mask_d)) begin
          state_d = PRESENT;
        end else begin
          state_d = COLLECT;
        end
      end
      PRESENT: begin
        if (bus.ballot_ready) begin
          state_d  = COLLECT;
          ballot_d = '0;
          mask_d   = '0;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d  = COLLECT;
        ballot_d = '0;
        mask_d   = '0;
      end
    endcase
  end

  // State and ballot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      ballot_q <= '0;
      mask_q   <= '0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ballot_q <= ballot_d;
      mask_q   <= mask_d;
      dup_q    <= dup_d;
    end
  end

  // Ready is gated by rst so no vote is offered while reset is held.
  assign bus.vote_ready   = ~rst & (state_q == COLLECT);
  assign bus.ballot_valid = (state_q == PRESENT);
  assign bus.ballot       = ballot_q;
  assign bus.ballot_mask  = mask_q;
  assign bus.dup_err      = dup_q;

`ifdef VOTING_BALLOT_TALLY_EN
  localparam int            MAJ_TH_INT = NUM_VOTERS / 2 + 1;
  localparam logic [ID_W:0] MAJ_TH     = MAJ_TH_INT[ID_W:0];

  logic [ID_W:0] tally_q, tally_d;
  logic          maj_q, maj_d;

  // Tally counts fresh yes votes only, so it always equals popcount(ballot).
  always_comb begin
    tally_d = tally_q;
    if ((state_q == PRESENT) && bus.ballot_ready) begin
      tally_d = '0;
    end else if (accept_s && !is_dup_s && bus.vote_value) begin
      tally_d = tally_q + {{ID_W{1'b0}}, 1'b1};
    end else begin
      tally_d = tally_q;
    end
    maj_d = (tally_d >= MAJ_TH);
  end

  // Tally and majority registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tally_q <= '0;
      maj_q   <= 1'b0;
    end else begin
      tally_q <= tally_d;
      maj_q   <= maj_d;
    end
  end

  assign bus.tally    = tally_q;
  assign bus.majority = maj_q;
`endif

endmodule

// File: doc/voting_ballot_collector.md
VOTING_BALLOT_COLLECTOR -- requirements
Module: voting_ballot_collector

Interface
REQ-001 SHALL have parameter NUM_VOTERS, default 16, number of voter slots (power of two, 2..64).
REQ-002 SHALL have parameter ID_W, default 4, voter ID width, equal to log2(NUM_VOTERS).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port vote_valid  input  1  voter presents a vote.
REQ-006 SHALL have port vote_ready  output  1  collector accepts a vote this cycle.
REQ-007 SHALL have port vote_id  input  ID_W  index of the voting slot.
REQ-008 SHALL have port vote_value  input  1  cast value (1 = yes).
REQ-009 SHALL have port close  input  1  single-cycle request to end collection early.
REQ-010 SHALL have port ballot_valid  output  1  ballot vector is presented to the voting circuit.
REQ-011 SHALL have port ballot_ready  input  1  voting circuit consumes the ballot.
REQ-012 SHALL have port ballot  output  NUM_VOTERS  collected votes, bit i = slot i; this is the p_input of the voting circuit.
REQ-013 SHALL have port ballot_mask  output  NUM_VOTERS  bit i set = slot i voted.
REQ-014 SHALL have port dup_err  output  1  one-cycle pulse: duplicate vote ignored.

Function
REQ-015 SHALL implement a two-state FSM: COLLECT and PRESENT.
REQ-016 In COLLECT, vote_ready SHALL be 1; in PRESENT, vote_ready SHALL be 0.
REQ-017 A vote SHALL be accepted when vote_valid & vote_ready are both high; ballot[vote_id] and ballot_mask[vote_id] SHALL update on the next edge (1-cycle latency).
REQ-018 An accepted vote whose ballot_mask bit is already set SHALL leave ballot unchanged and SHALL raise dup_err for exactly the following cycle.
REQ-019 COLLECT SHALL go to PRESENT on the edge after the vote that sets the last mask bit is accepted.
REQ-020 COLLECT SHALL go to PRESENT on the edge after close is high.
REQ-021 When close and a valid vote occur in the same cycle, the vote SHALL be included in the ballot.
REQ-022 close SHALL be ignored in PRESENT.
REQ-023 In PRESENT, ballot_valid SHALL be 1, and ballot and ballot_mask SHALL be held stable until the handshake.
REQ-024 On ballot_valid & ballot_ready, the FSM SHALL return to COLLECT on the next edge with ballot and ballot_mask cleared.
REQ-025 Slots that did not vote SHALL read 0 in both ballot and ballot_mask.
REQ-026 close with zero votes collected SHALL still produce a presentation of an all-zero ballot.

Reset
REQ-027 On rst, the FSM SHALL enter COLLECT, and ballot, ballot_mask, dup_err and ballot_valid SHALL be 0.
REQ-028 rst SHALL override all activity, including a handshake in progress.
REQ-029 While rst is high, vote_ready SHALL be 0.
REQ-030 vote_ready SHALL be 1 from the first cycle after rst is released.

Configuration
REQ-031 When macro VOTING_BALLOT_TALLY_EN is defined, the block SHALL add the following outputs, registered and updated alongside ballot, and valid whenever ballot_valid is high:
- tally: ID_W+1 bits, popcount of ballot.
- majority: 1 when tally >= NUM_VOTERS/2+1.
REQ-032 When VOTING_BALLOT_TALLY_EN is undefined, these ports and their logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 The shared package voting_pkg SHALL hold:
- NUM_VOTERS_DEF (16) and ID_W_DEF (4);
- the FSM state enum type {COLLECT, PRESENT}.
REQ-034 The tally SHALL be implemented incrementally: tally increments on each non-duplicate yes vote, with no popcount tree; the block SHALL have no sub-modules.

Verification
REQ-035 Bench SHALL cover: ids 0..15, one per cycle, value = id[0], ready held high -> ballot_valid rises the cycle after id 15; ballot=16'hAAAA, mask=16'hFFFF; with the tally macro, tally=8 and majority=0.
REQ-036 Bench SHALL cover: votes id3=1, id3=0 -> dup_err pulses once; ballot[3] stays 1.
REQ-037 Bench SHALL cover: votes id0=1, id5=1, then close -> ballot=16'h0021, mask=16'h0021; ballot_valid rises 1 cycle after close.
REQ-038 Bench SHALL cover: ballot_ready held low for 10 cycles in PRESENT while vote_valid toggles -> ballot stable, vote_ready=0, no state change; ballot_ready=1 -> COLLECT next cycle with ballot=0.
REQ-039 Bench SHALL cover: rst asserted during PRESENT -> next cycle ballot_valid=0, ballot=0, mask=0, and vote_ready=1 after release.
REQ-040 Bench SHALL cover: close and vote id7=1 in the same cycle -> presented ballot=16'h0080.
